// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - walks a ROM command table and feeds the SPI master, checking readback
module spi_cmd_sequencer #(
    parameter int CMD_WIDTH      = 12,
    parameter int READ_WIDTH     = 8,
    parameter int NUM_CMDS       = 8,
    parameter int IDX_W          = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [IDX_W-1:0]      tbl_idx,
    input  logic [CMD_WIDTH-1:0]  tbl_cmd,
    input  logic [READ_WIDTH-1:0] tbl_exp,
    output logic [CMD_WIDTH-1:0]  cmd_out,
    output logic                  cmd_vld,
    input  logic                  cmd_rdy,
    input  logic                  read_vld,
    input  logic [READ_WIDTH-1:0] read_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [IDX_W-1:0]      err_idx,
    output logic                  timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0]    GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CMDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_DONE,
        S_GAP,
        S_FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
    logic [READ_WIDTH-1:0] exp_q, exp_d;
    logic                  saw_low_q, saw_low_d;
    logic                  got_rd_q, got_rd_d;
    logic [READ_WIDTH-1:0] rd_q, rd_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  err_q, err_d;
    logic [IDX_W-1:0]      err_idx_q, err_idx_d;
    logic                  timeout_q, timeout_d;

    logic                  is_write;
    logic                  have_rd;
    logic                  xfer_done;
    logic                  advance;
    logic [READ_WIDTH-1:0] rd_cur;

    // State and datapath registers; reset clears everything to the idle picture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cmd_q     <= '0;
            exp_q     <= '0;
            saw_low_q <= 1'b0;
            got_rd_q  <= 1'b0;
            rd_q      <= '0;
            tmo_q     <= '0;
            gap_q     <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cmd_q     <= cmd_d;
            exp_q     <= exp_d;
            saw_low_q <= saw_low_d;
            got_rd_q  <= got_rd_d;
            rd_q      <= rd_d;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: table walk, transfer completion tracking, readback compare and timeout.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cmd_d     = cmd_q;
        exp_d     = exp_q;
        saw_low_d = saw_low_q;
        got_rd_d  = got_rd_q;
        rd_d      = rd_q;
        tmo_d     = tmo_q;
        gap_d     = gap_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        timeout_d = timeout_q;
        advance   = 1'b0;

        is_write  = cmd_q[CMD_WIDTH-1];
        // A read byte arriving in the completing cycle counts, so use it directly if none was held yet.
        rd_cur    = got_rd_q ? rd_q : read_data;
        have_rd   = is_write | got_rd_q | read_vld;
        xfer_done = saw_low_q & cmd_rdy & have_rd;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d     = '0;
                    err_d     = 1'b0;
                    err_idx_d = '0;
                    timeout_d = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                cmd_d   = tbl_cmd;
                exp_d   = tbl_exp;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (cmd_rdy) begin
                    saw_low_d = 1'b0;
                    got_rd_d  = 1'b0;
                    tmo_d     = '0;
                    state_d   = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!is_write && !got_rd_q && read_vld) begin
                    got_rd_d = 1'b1;
                    rd_d     = read_data;
                end
                if (!cmd_rdy) begin
                    saw_low_d = 1'b1;
                end
                if (xfer_done) begin
                    if (!is_write && (rd_cur != exp_q) && !err_q) begin
                        err_d     = 1'b1;
                        err_idx_d = idx_q;
                    end
                    gap_d = '0;
                    if (GAP_CYCLES == 0) begin
                        advance = 1'b1;
                    end else begin
                        state_d = S_GAP;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    if (!err_q) begin
                        err_idx_d = idx_q;
                    end
                    state_d = S_FINISH;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    advance = 1'b1;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Leaving the gap (or skipping it): either the last entry is done or move to the next one.
        if (advance) begin
            if (idx_q == LAST_IDX) begin
                state_d = S_FINISH;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = S_FETCH;
            end
        end
    end

    assign tbl_idx = idx_q;
    assign cmd_out = cmd_q;
    assign cmd_vld = (state_q == S_ISSUE);
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_FINISH);
    assign err     = err_q;
    assign err_idx = err_idx_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb/tb_spi_cmd_sequencer.sv - randomized self-checking bench for spi_cmd_sequencer
module tb_spi_cmd_sequencer;

    localparam int NUM = 3;
    localparam int GAP = 16;
    localparam int TMO = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  tbl_idx;
    logic [11:0] tbl_cmd;
    logic [7:0]  tbl_exp;
    logic [11:0] cmd_out;
    logic        cmd_vld;
    logic        cmd_rdy = 1'b1;
    logic        read_vld = 1'b0;
    logic [7:0]  read_data = 8'h00;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  err_idx;
    logic        timeout;

    spi_cmd_sequencer #(
        .CMD_WIDTH(12), .READ_WIDTH(8), .NUM_CMDS(NUM), .IDX_W(4),
        .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .tbl_idx(tbl_idx), .tbl_cmd(tbl_cmd), .tbl_exp(tbl_exp),
        .cmd_out(cmd_out), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .read_vld(read_vld), .read_data(read_data),
        .busy(busy), .done(done), .err(err), .err_idx(err_idx), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Command table ROM
    logic [11:0] rom_cmd [0:15];
    logic [7:0]  rom_exp [0:15];
    logic [7:0]  resp    [0:15];
    assign tbl_cmd = rom_cmd[tbl_idx];
    assign tbl_exp = rom_exp[tbl_idx];

    int n_tests = 0;
    int n_fail  = 0;

    // SPI master model state
    logic [11:0] obs_q [$];
    logic        sc_rdy [$];
    logic        sc_rv [$];
    logic [7:0]  sc_rd [$];
    int  acc_cnt = 0;
    int  hang_at = -1;
    int  stall_left = 0;
    int  vld_wait_cnt = 0;
    int  unstable_cnt = 0;
    int  idle_run = 0;
    int  min_gap = 1000;
    int  done_cnt = 0;
    bit  hang_active = 0;
    bit  noise_en = 0;
    bit  seen_pulse = 0;
    bit  prev_vld = 0;
    logic [11:0] prev_cmd = 12'h000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Per-transfer response script: busy for L cycles, read byte somewhere (possibly after ready returns)
    task automatic push_script(input logic [11:0] c, input int i);
        int l, p, s;
        logic rv;
        logic [7:0] rd;
        l = $urandom_range(1, 4);
        p = c[11] ? -1 : int'($urandom_range(0, l + 2));
        s = ((p > l) ? p : l) + 1;
        for (int j = 0; j < s; j++) begin
            rv = (j == p);
            rd = rv ? resp[i] : 8'($urandom);
            if (!c[11] && p < l && j == p + 1) begin
                rv = 1'b1;
                rd = ~resp[i];
            end
            if (c[11] && noise_en && j == 0) begin
                rv = 1'b1;
                rd = 8'($urandom);
            end
            sc_rdy.push_back(j >= l);
            sc_rv.push_back(rv);
            sc_rd.push_back(rd);
        end
    endtask

    // Master model: drives handshake inputs on the falling edge and watches outputs there
    always @(negedge clk) begin
        if (!rst_n) begin
            sc_rdy.delete();
            sc_rv.delete();
            sc_rd.delete();
            hang_active = 0;
            cmd_rdy     = 1'b1;
            read_vld    = 1'b0;
            read_data   = 8'h00;
            prev_vld    = 0;
        end else begin
            if (sc_rdy.size() > 0) begin
                cmd_rdy   = sc_rdy.pop_front();
                read_vld  = sc_rv.pop_front();
                read_data = sc_rd.pop_front();
            end else begin
                cmd_rdy   = !(hang_active || stall_left > 0);
                read_vld  = noise_en && ($urandom_range(0, 3) == 0);
                read_data = 8'($urandom);
            end
            if (done) done_cnt++;
            if (cmd_vld && prev_vld && cmd_out !== prev_cmd) unstable_cnt++;
            if (cmd_vld && !prev_vld) begin
                if (seen_pulse && idle_run < min_gap) min_gap = idle_run;
                seen_pulse = 1;
            end
            if (cmd_vld) idle_run = 0;
            else idle_run++;
            if (cmd_vld && !cmd_rdy) begin
                vld_wait_cnt++;
                if (stall_left > 0) stall_left--;
            end
            if (cmd_vld && cmd_rdy) begin
                obs_q.push_back(cmd_out);
                if (acc_cnt == hang_at) hang_active = 1;
                else push_script(cmd_out, acc_cnt);
                acc_cnt++;
            end
            prev_vld = cmd_vld;
            prev_cmd = cmd_out;
        end
    end

    task automatic begin_run(input int hang, input bit noise, input int stall);
        @(posedge clk);
        #1;
        obs_q.delete();
        acc_cnt = 0; hang_active = 0; done_cnt = 0; vld_wait_cnt = 0;
        unstable_cnt = 0; min_gap = 1000; seen_pulse = 0; idle_run = 0;
        hang_at = hang; noise_en = noise; stall_left = stall;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Whole-run prediction: walk the table in order, stop at the hung entry
    task automatic run_and_check(input string name, input int hang, input bit noise,
                                 input bit extra, input int stall);
        int  n_issue;
        bit  e_err, e_to, got;
        int  e_idx;
        begin_run(hang, noise, stall);
        got = 0;
        for (int k = 0; k < 3 * TMO; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got = 1;
                break;
            end
            start = extra && ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        check({name, ":done_seen"}, got, 1);
        check({name, ":busy_at_done"}, busy, 1);
        @(posedge clk);
        #1;
        check({name, ":busy_after"}, busy, 0);
        check({name, ":done_len"}, done_cnt, 1);

        n_issue = NUM; e_err = 0; e_idx = 0; e_to = 0;
        for (int i = 0; i < NUM; i++) begin
            if (i == hang) begin
                n_issue = i + 1;
                e_to = 1;
                if (!e_err) begin e_err = 1; e_idx = i; end
                break;
            end
            if (!rom_cmd[i][11] && resp[i] != rom_exp[i] && !e_err) begin
                e_err = 1; e_idx = i;
            end
        end
        check({name, ":n_issued"}, obs_q.size(), n_issue);
        for (int i = 0; i < n_issue && i < obs_q.size(); i++)
            check($sformatf("%s:cmd_out[%0d]", name, i), obs_q[i], rom_cmd[i]);
        check({name, ":err"}, err, e_err);
        check({name, ":err_idx"}, err_idx, e_idx);
        check({name, ":timeout"}, timeout, e_to);
        check({name, ":vld_wait"}, vld_wait_cnt, stall);
        check({name, ":cmd_stable"}, unstable_cnt, 0);
        if (n_issue > 1) check({name, ":min_gap_ok"}, min_gap >= GAP, 1);
    endtask

    task automatic load_basic(input logic [7:0] rdval);
        rom_cmd[0] = 12'h8A5; rom_exp[0] = 8'h00; resp[0] = 8'h00;
        rom_cmd[1] = 12'h9F0; rom_exp[1] = 8'h00; resp[1] = 8'h00;
        rom_cmd[2] = 12'h300; rom_exp[2] = 8'h5A; resp[2] = rdval;
    endtask

    initial begin
        bit got;
        for (int i = 0; i < 16; i++) begin
            rom_cmd[i] = 12'h000; rom_exp[i] = 8'h00; resp[i] = 8'h00;
        end
        #1;
        check("rst:cmd_vld", cmd_vld, 0);
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:err", err, 0);
        check("rst:timeout", timeout, 0);
        check("rst:tbl_idx", tbl_idx, 0);
        check("rst:cmd_out", cmd_out, 0);
        check("rst:err_idx", err_idx, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        load_basic(8'h5A);
        run_and_check("t1_pass", -1, 0, 0, 0);

        load_basic(8'h5B);
        run_and_check("t2_mismatch", -1, 0, 0, 0);

        load_basic(8'h5A);
        run_and_check("t3_timeout", 1, 0, 0, 0);

        load_basic(8'h5A);
        run_and_check("t4_stall", -1, 0, 0, 50);

        // Reset in the middle of a transfer wait, with err already raised by entry 0
        rom_cmd[0] = 12'h011; rom_exp[0] = 8'h11; resp[0] = 8'h22;
        rom_cmd[1] = 12'h8C3; rom_exp[1] = 8'h00; resp[1] = 8'h00;
        rom_cmd[2] = 12'h822; rom_exp[2] = 8'h00; resp[2] = 8'h00;
        begin_run(-1, 0, 0);
        got = 0;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            #1;
            if (acc_cnt >= 2) begin
                got = 1;
                break;
            end
        end
        check("t5:reached_entry1", got, 1);
        @(negedge clk);
        #2;
        check("t5:busy_pre", busy, 1);
        check("t5:err_pre", err, 1);
        rst_n = 1'b0;
        #1;
        check("t5:cmd_vld", cmd_vld, 0);
        check("t5:busy", busy, 0);
        check("t5:done", done, 0);
        check("t5:err", err, 0);
        check("t5:tbl_idx", tbl_idx, 0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        run_and_check("t5_restart", -1, 0, 0, 0);

        // Start pulses while busy and read_vld noise during writes and idle states
        rom_cmd[0] = 12'hA10; rom_exp[0] = 8'h00; resp[0] = 8'h00;
        rom_cmd[1] = 12'h0C5; rom_exp[1] = 8'h3C; resp[1] = 8'h3C;
        rom_cmd[2] = 12'hF0F; rom_exp[2] = 8'h00; resp[2] = 8'h00;
        run_and_check("t6_noise", -1, 1, 1, 0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NUM; i++) begin
                rom_cmd[i] = 12'($urandom);
                rom_exp[i] = 8'($urandom);
                resp[i] = ($urandom_range(0, 2) == 0) ? rom_exp[i] ^ 8'($urandom_range(1, 255))
                                                     : rom_exp[i];
            end
            run_and_check($sformatf("rand%0d", r),
                          (r % 3 == 2) ? int'($urandom_range(0, NUM - 1)) : -1,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_cmd_sequencer.md
Name: spi_cmd_sequencer

Overview:
- Upstream feeder for the SPI master. Walks a command table held in an external synchronous ROM and issues each entry over the master's cmd_vld/cmd_rdy handshake.
- Waits for each transfer to complete. For read commands, captures the returned byte and compares it against an expected value.
- Used for device power-up register initialisation and readback verification. Reports busy, done, mismatch and timeout status.

Parameters:
- CMD_WIDTH, 12, command word width; bit CMD_WIDTH-1 = 1 means write, 0 means read.
- READ_WIDTH, 8, read-data and expected-value width.
- NUM_CMDS, 8, number of table entries executed per run; range 1..16.
- IDX_W, 4, table index width.
- GAP_CYCLES, 16, idle clocks between commands; 0 is legal.
- TIMEOUT_CYCLES, 4096, maximum clocks spent waiting for one transfer to complete.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle run request; sampled only in IDLE.
- tbl_idx  out  IDX_W  ROM address.
- tbl_cmd  in  CMD_WIDTH  ROM command word; valid one clock after tbl_idx changes.
- tbl_exp  in  READ_WIDTH  ROM expected read value; same timing as tbl_cmd.
- cmd_out  out  CMD_WIDTH  command to the SPI master.
- cmd_vld  out  1  command valid.
- cmd_rdy  in  1  SPI master ready; high when idle, low while a transfer runs.
- read_vld  in  1  SPI master read-data valid.
- read_data  in  READ_WIDTH  SPI master read byte.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- err  out  1  sticky; readback mismatch or timeout occurred in the last run.
- err_idx  out  IDX_W  index of the first failing entry.
- timeout  out  1  sticky; the last run was aborted by timeout.

Behaviour:
- Reset values (asynchronous, effective immediately, including mid-run):
  - state IDLE.
  - tbl_idx, cmd_out, cmd_vld, busy, done, err, err_idx, timeout, and all counters = 0.
- States: IDLE, FETCH, ISSUE, WAIT_DONE, GAP, FINISH.
- IDLE:
  - start=1 → idx=0; clear err, err_idx, timeout; busy=1; go to FETCH.
  - start in any other state is ignored.
- FETCH: exactly 1 cycle (ROM latency). At exit, latch tbl_cmd into cmd_out and tbl_exp into exp_reg. Go to ISSUE.
- ISSUE:
  - cmd_vld=1; cmd_out is stable while cmd_vld=1.
  - Accept on cmd_vld & cmd_rdy in the same cycle.
  - Next cycle: cmd_vld=0, go to WAIT_DONE.
  - Time spent in ISSUE before acceptance is unbounded and not timed.
- WAIT_DONE:
  - Completion requires both: cmd_rdy sampled low at least once after acceptance, then sampled high again.
  - Read command additionally requires: read_vld seen since acceptance, capturing read_data on the first read_vld only. If cmd_rdy returns high before read_vld, keep waiting for read_vld.
  - read_vld during a write command is ignored.
  - read_vld in any state other than WAIT_DONE is ignored.
  - Read compare: if captured data != exp_reg and err=0 → err=1, err_idx=idx. The run continues; only the first failure is recorded.
  - Timeout counter starts at 0 on entry and increments every cycle. On reaching TIMEOUT_CYCLES-1 without completion:
    - err=1, timeout=1.
    - err_idx=idx if err was 0.
    - go to FINISH; remaining entries are skipped.
  - Timeout and completion in the same cycle: completion wins.
- GAP:
  - Counts GAP_CYCLES clocks, then:
    - idx == NUM_CMDS-1 → FINISH.
    - otherwise idx+1 → FETCH.
  - GAP_CYCLES=0 → zero cycles in GAP; GAP is evaluated as a pass-through in the same cycle the transfer completes.
- FINISH: 1 cycle; done=1, busy=0 from the next cycle, then IDLE. err, err_idx and timeout hold until the next start.
- tbl_idx = idx at all times.
- idx never wraps within a run.
- Counter widths must hold TIMEOUT_CYCLES-1 and GAP_CYCLES without overflow.

Test Plan:
1. NUM_CMDS=3, GAP=16. ROM = {0x8A5 write, 0x9F0 write, 0x300 read exp 0x5A}; master model returns 0x5A → three handshakes; cmd_out values 0x8A5, 0x9F0, 0x300 in order; done pulse; err=0; ≥16 idle clocks between cmd_vld pulses.
2. Same table, master returns 0x5B on the read → run completes; err=1, err_idx=2, timeout=0.
3. Master holds cmd_rdy=0 after accepting entry 1 → after TIMEOUT_CYCLES, timeout=1, err_idx=1; entry 2 is never issued; done pulse.
4. cmd_rdy held low for 50 cycles while in ISSUE → cmd_vld stays 1 and cmd_out is stable; issue proceeds on the first cmd_rdy=1; no timeout.
5. Assert rst_n=0 mid-WAIT_DONE → cmd_vld, busy, done, err = 0 in the same cycle; a later start restarts from idx 0.
6. start pulses while busy, plus read_vld pulses during a write entry → no restart; no capture; err unchanged.
